mul_32b_seq: RTL and testbench

- Multi-cycle 32x32 -> 64-bit multiplier; the inverse-operation companion to the sequential divider in the same arithmetic lab.
- Uses a radix-2 Booth algorithm with one add/subtract-and-shift step per clock.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Feeds the lab's ALU/result display path through the same in_valid/out_valid handshake as the divider.

---
 rtl/mul_32b_seq_if.sv | 24 ++
 rtl/mul_32b_seq.sv | 139 +++++++++++++
 tb/tb_mul_32b_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_32b_seq_if.sv
// Handshake/operand bundle for the sequential Booth multiplier.
// The master drives operands and the start request; the slave (the
// multiplier) returns busy, the one-cycle result strobe and the product.
interface mul_32b_seq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0]   X;
   logic [WIDTH-1:0]   Y;
   logic               is_signed;
   logic               in_valid;
   logic               busy;
   logic               out_valid;
   logic [2*WIDTH-1:0] P;

   modport master (
      output X, Y, is_signed, in_valid,
      input  busy, out_valid, P
   );

   modport slave (
      input  X, Y, is_signed, in_valid,
      output busy, out_valid, P
   );
endinterface

// File: rtl/mul_32b_seq.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2 Booth, one
// add/subtract-and-shift step per clock. Operands are extended by one bit
// (sign or zero) so a single signed Booth engine covers both signed and
// unsigned multiplication; WIDTH+1 steps produce the full product.
module mul_32b_seq #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   mul_32b_seq_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH:0]     r_a;
   logic [WIDTH:0]     r_q;
   logic [WIDTH:0]     r_mx;
   logic               r_q1;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_p;
   logic               r_busy;
   logic               r_out_valid;

   logic               w_accept;
   logic               w_zero;
   logic               w_last;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH+1:0] w_shift;

   // Extend an operand to WIDTH+1 bits: sign-extend when signed, else zero-extend.
   function automatic logic [WIDTH:0] f_ext(input logic [WIDTH-1:0] v, input logic sgn);
      return {sgn & v[WIDTH-1], v};
   endfunction

   assign w_zero = (bus.X == {WIDTH{1'b0}}) || (bus.Y == {WIDTH{1'b0}});
   assign w_last = (r_cnt == CW'(1));

   // A start is taken whenever the engine is idle or presenting a result.
   always_comb begin
      w_accept = 1'b0;
      if (bus.in_valid && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
         w_accept = 1'b1;
      end else begin
         w_accept = 1'b0;
      end
   end

   // One Booth step: recode {Q[0], q_1}, add/subtract Mx, then arithmetic shift of {A,Q}.
   always_comb begin
      w_sum = r_a;
      case ({r_q[0], r_q1})
         2'b10:   w_sum = r_a - r_mx;
         2'b01:   w_sum = r_a + r_mx;
         default: w_sum = r_a;
      endcase
      w_shift = {w_sum[WIDTH], w_sum, r_q[WIDTH:1]};
   end

   // Next-state logic for IDLE -> CALC -> DONE, with back-to-back restart from DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_CALC;
            else          w_state_nxt = S_IDLE;
         end
         S_CALC: begin
            if (w_last) w_state_nxt = S_DONE;
            else        w_state_nxt = S_CALC;
         end
         S_DONE: begin
            if (w_accept) w_state_nxt = S_CALC;
            else          w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register plus registered status flags decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_busy      <= (w_state_nxt == S_CALC);
         r_out_valid <= (w_state_nxt == S_DONE);
      end
   end

   // Datapath: load operands on accept, iterate in CALC, capture P on the final step.
   // A zero operand loads Mx=Q=0 with a single step, so the one pass through CALC yields 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= {(WIDTH+1){1'b0}};
         r_q   <= {(WIDTH+1){1'b0}};
         r_mx  <= {(WIDTH+1){1'b0}};
         r_q1  <= 1'b0;
         r_cnt <= {CW{1'b0}};
         r_p   <= {(2*WIDTH){1'b0}};
      end else if (w_accept) begin
         r_a  <= {(WIDTH+1){1'b0}};
         r_q1 <= 1'b0;
         r_p  <= {(2*WIDTH){1'b0}};
         if (w_zero) begin
            r_mx  <= {(WIDTH+1){1'b0}};
            r_q   <= {(WIDTH+1){1'b0}};
            r_cnt <= CW'(1);
         end else begin
            r_mx  <= f_ext(bus.X, bus.is_signed);
            r_q   <= f_ext(bus.Y, bus.is_signed);
            r_cnt <= CW'(WIDTH + 1);
         end
      end else if (r_state == S_CALC) begin
         r_a   <= w_shift[2*WIDTH+1:WIDTH+1];
         r_q   <= w_shift[WIDTH:0];
         r_q1  <= r_q[0];
         r_cnt <= r_cnt - CW'(1);
         if (w_last) r_p <= w_shift[2*WIDTH-1:0];
         else        r_p <= r_p;
      end else begin
         r_p <= r_p;
      end
   end

   assign bus.busy      = r_busy;
   assign bus.out_valid = r_out_valid;
   assign bus.P         = r_p;

endmodule

// File: tb/tb_mul_32b_seq.sv
// Self-checking bench for mul_32b_seq: directed cases plus randomized
// operands compared against a plain-arithmetic product model.
module tb_mul_32b_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   mul_32b_seq_if #(.WIDTH(32)) bus ();

   mul_32b_seq #(.WIDTH(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference product from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
      longint      sx, sy;
      logic [63:0] ux, uy;
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end else begin
         ux = {32'd0, x};
         uy = {32'd0, y};
         return ux * uy;
      end
   endfunction

   // Advance to 1ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive operands with in_valid=1 and step through the accepting edge.
   task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s, input bit keep_valid);
      bus.X         = x;
      bus.Y         = y;
      bus.is_signed = s;
      bus.in_valid  = 1'b1;
      tick();
      if (!keep_valid) bus.in_valid = 1'b0;
   endtask

   // Count cycles after the accept edge until out_valid appears; -1 on timeout.
   task automatic wait_done(input bit scramble, output int n);
      n = 0;
      while (bus.out_valid !== 1'b1) begin
         if (n >= 40) begin
            n = -1;
            return;
         end
         if (scramble) begin
            bus.X = $urandom;
            bus.Y = $urandom;
            bus.is_signed = 1'($urandom_range(0, 1));
         end
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n_ov;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (bus.P !== 64'd0) $display("FAIL reset_P got=%h exp=0", bus.P); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
      // abort mid-operation
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (bus.P !== 64'd0) $display("FAIL abort_P got=%h exp=0", bus.P); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy); else n_pass++;
      n_ov = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid === 1'b1) n_ov++;
      end
      n_checks++; if (n_ov !== 0) $display("FAIL abort_no_strobe got=%0d strobes exp=0", n_ov); else n_pass++;
   endtask

   task automatic test_directed();
      logic [31:0] xs [3];
      logic [31:0] ys [3];
      logic        ss [3];
      logic [63:0] ps [3];
      int n;
      xs[0] = 32'hFFFF_FFFF; ys[0] = 32'hFFFF_FFFF; ss[0] = 1'b0; ps[0] = 64'hFFFF_FFFE_0000_0001;
      xs[1] = 32'hFFFF_FFF9; ys[1] = 32'd6;         ss[1] = 1'b1; ps[1] = 64'hFFFF_FFFF_FFFF_FFD6;
      xs[2] = 32'h8000_0000; ys[2] = 32'h8000_0000; ss[2] = 1'b1; ps[2] = 64'h4000_0000_0000_0000;
      for (int k = 0; k < 3; k++) begin
         start_op(xs[k], ys[k], ss[k], 1'b0);
         n_checks++; if (bus.busy !== 1'b1) $display("FAIL dir%0d_busy got=%b exp=1", k, bus.busy); else n_pass++;
         wait_done(1'b0, n);
         n_checks++; if (n !== 33) $display("FAIL dir%0d_latency got=%0d exp=33", k, n); else n_pass++;
         n_checks++; if (bus.P !== ps[k]) $display("FAIL dir%0d_P got=%h exp=%h", k, bus.P, ps[k]); else n_pass++;
         tick();
         n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL dir%0d_strobe_width got=%b exp=0", k, bus.out_valid); else n_pass++;
         tick();
         n_checks++; if (bus.P !== ps[k]) $display("FAIL dir%0d_P_hold got=%h exp=%h", k, bus.P, ps[k]); else n_pass++;
      end
   endtask

   task automatic test_zero();
      int n;
      start_op(32'd0, 32'h1234, 1'b0, 1'b0);
      n_checks++; if (bus.busy !== 1'b1) $display("FAIL zero_busy got=%b exp=1", bus.busy); else n_pass++;
      wait_done(1'b0, n);
      n_checks++; if (n !== 1) $display("FAIL zero_latency got=%0d exp=1", n); else n_pass++;
      n_checks++; if (bus.P !== 64'd0) $display("FAIL zero_P got=%h exp=0", bus.P); else n_pass++;
      tick();
      start_op(32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
      wait_done(1'b0, n);
      n_checks++; if (n !== 1) $display("FAIL zeroY_latency got=%0d exp=1", n); else n_pass++;
      n_checks++; if (bus.P !== 64'd0) $display("FAIL zeroY_P got=%h exp=0", bus.P); else n_pass++;
      tick();
   endtask

   task automatic test_ignore();
      int n;
      start_op(32'h10, 32'h10, 1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 9; i++) begin tick(); n++; end
      bus.X = 32'd3; bus.Y = 32'd5; bus.in_valid = 1'b1;
      tick(); n++;
      bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 33) $display("FAIL ignore_latency got=%0d exp=33", n); else n_pass++;
      n_checks++; if (bus.P !== 64'h100) $display("FAIL ignore_P got=%h exp=100", bus.P); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      start_op(32'd7, 32'd9, 1'b0, 1'b0);
      wait_done(1'b0, n);
      n_checks++; if (bus.P !== 64'd63) $display("FAIL b2b_first_P got=%h exp=3f", bus.P); else n_pass++;
      start_op(32'd3, 32'd5, 1'b0, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_strobe_drop got=%b exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", bus.busy); else n_pass++;
      n_checks++; if (bus.P !== 64'd0) $display("FAIL b2b_P_cleared got=%h exp=0", bus.P); else n_pass++;
      wait_done(1'b0, n);
      n_checks++; if (n !== 33) $display("FAIL b2b_latency got=%0d exp=33", n); else n_pass++;
      n_checks++; if (bus.P !== 64'd15) $display("FAIL b2b_P got=%h exp=f", bus.P); else n_pass++;
      tick();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] x, y;
      logic        s;
      logic [63:0] exp_p;
      int          n, exp_n;
      bit          cont;
      for (int i = 0; i < 1000; i++) begin
         x = pick_operand();
         y = pick_operand();
         s = 1'($urandom_range(0, 1));
         cont = (i >= 500);
         exp_p = ref_mul(x, y, s);
         exp_n = ((x == 32'd0) || (y == 32'd0)) ? 1 : 33;
         start_op(x, y, s, cont);
         wait_done(cont, n);
         n_checks++; if (n !== exp_n) $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, n, exp_n); else n_pass++;
         n_checks++; if (bus.P !== exp_p) $display("FAIL rnd%0d_P x=%h y=%h s=%b got=%h exp=%h", i, x, y, s, bus.P, exp_p); else n_pass++;
         if (!cont && ($urandom_range(0, 3) == 0)) tick();
      end
      bus.in_valid = 1'b0;
      tick();
   endtask

   initial begin
      bus.X = 32'd0;
      bus.Y = 32'd0;
      bus.is_signed = 1'b0;
      bus.in_valid = 1'b0;
      test_reset();
      test_directed();
      test_zero();
      test_ignore();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
